ps2_key_decoder: RTL and testbench

Parametrised, fully synchronous PS/2 keyboard receiver for the keyboard path: filters `kclk`/`kdata` in the `clk` domain and frames 11-bit PS/2 packets with start, parity and stop checks plus a watchdog timeout. It folds the `E0` (extended) and `F0` (break) prefixes into single key events and buffers them in a first-word-fall-through FIFO, so game logic pops complete make/break events.

---
 rtl/ps2_key_decoder.sv | 239 +++++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 keyboard receiver with E0/F0 folding and FWFT event FIFO (optional PS2_PARITY_CHECK_EN)
`timescale 1ns/1ps
module ps2_key_decoder #(
  parameter int FILTER_LEN     = 19,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       kclk,
  input  logic       kdata,
  input  logic       rd_en,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       fifo_full,
  output logic       frame_err,
  output logic       overflow
);

  localparam int FCW = $clog2(FILTER_LEN + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [1:0]     clk_sync, dat_sync;
  logic           clk_f, dat_f;
  logic [FCW-1:0] clk_cnt, dat_cnt;
  logic           clk_prev, fall;
  state_t         state, state_nxt;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift_reg;
  logic [TW-1:0]  wdog;
  logic           timeout, stop_fall, parity_ok, deliver, err_now;
  logic           byte_valid;
  logic [7:0]     byte_data;
  logic           ext_flag, brk_flag;
  logic           push, pop, wr;
  logic [9:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic [CW-1:0]  count, count_nxt;
  logic           is_full, is_empty;
  logic [9:0]     head;
`ifdef PS2_PARITY_CHECK_EN
  logic           par_bit;
`endif

  // Two-flop synchronisers for the asynchronous PS/2 lines; idle level is high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], kclk};
      dat_sync <= {dat_sync[0], kdata};
    end
  end

  // Clock-line glitch filter: follow the synchronised value only after FILTER_LEN agreeing samples
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_f   <= 1'b1;
      clk_cnt <= '0;
    end else if (clk_sync[1] == clk_f) begin
      clk_cnt <= '0;
    end else if (clk_cnt == FCW'(FILTER_LEN - 1)) begin
      clk_f   <= clk_sync[1];
      clk_cnt <= '0;
    end else begin
      clk_cnt <= clk_cnt + 1'b1;
    end
  end

  // Data-line glitch filter, same rule as the clock line
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dat_f   <= 1'b1;
      dat_cnt <= '0;
    end else if (dat_sync[1] == dat_f) begin
      dat_cnt <= '0;
    end else if (dat_cnt == FCW'(FILTER_LEN - 1)) begin
      dat_f   <= dat_sync[1];
      dat_cnt <= '0;
    end else begin
      dat_cnt <= dat_cnt + 1'b1;
    end
  end

  // Registered one-cycle strobe on each falling edge of the filtered clock
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_prev <= 1'b1;
      fall     <= 1'b0;
    end else begin
      clk_prev <= clk_f;
      fall     <= clk_prev & ~clk_f;
    end
  end

  // Frame FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Frame FSM next state; a watchdog expiry abandons any partial frame
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (fall && !dat_f) state_nxt = S_DATA;
      S_DATA:   if (timeout) state_nxt = S_IDLE;
                else if (fall && bit_cnt == 3'd7) state_nxt = S_PARITY;
      S_PARITY: if (timeout) state_nxt = S_IDLE;
                else if (fall) state_nxt = S_STOP;
      S_STOP:   if (timeout || fall) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Frame FSM outputs: stop-bit/parity verdict and watchdog expiry
  always_comb begin
    timeout   = (state != S_IDLE) && !fall && (wdog == TW'(TIMEOUT_CYCLES - 1));
    stop_fall = (state == S_STOP) && fall;
`ifdef PS2_PARITY_CHECK_EN
    parity_ok = ^{shift_reg, par_bit};
`else
    parity_ok = 1'b1;
`endif
    deliver   = stop_fall && dat_f && parity_ok;
    err_now   = (stop_fall && !(dat_f && parity_ok)) || timeout;
  end

  // Bit shifter, bit counter and watchdog; the watchdog only runs inside a frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
      wdog      <= '0;
    end else begin
      if (state == S_IDLE) begin
        wdog    <= '0;
        bit_cnt <= '0;
      end else if (fall) begin
        wdog    <= '0;
      end else begin
        wdog    <= wdog + 1'b1;
      end
      if (fall && state == S_DATA) begin
        shift_reg <= {dat_f, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 1'b1;
      end
    end
  end

`ifdef PS2_PARITY_CHECK_EN
  // Parity bit capture for the odd-parity check
  always_ff @(posedge clk) begin
    if (!rst_n)                          par_bit <= 1'b0;
    else if (fall && state == S_PARITY) par_bit <= dat_f;
  end
`endif

  // Completed byte and error strobe, both one cycle after the stop-bit edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= deliver;
      byte_data  <= shift_reg;
      frame_err  <= err_now;
    end
  end

  // Prefix flags: E0/F0 accumulate until a key byte consumes them or a frame error discards them
  always_ff @(posedge clk) begin
    if (!rst_n || frame_err) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
    end else if (byte_valid) begin
      if (byte_data == 8'hE0) begin
        ext_flag <= 1'b1;
      end else if (byte_data == 8'hF0) begin
        brk_flag <= 1'b1;
      end else begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end
    end
  end

  // FIFO control; a pop frees the slot so push succeeds even when full
  always_comb begin
    push      = byte_valid && (byte_data != 8'hE0) && (byte_data != 8'hF0);
    is_full   = (count == CW'(FIFO_DEPTH));
    is_empty  = (count == '0);
    pop       = rd_en && !is_empty;
    wr        = push && (!is_full || pop);
    count_nxt = count;
    if (wr && !pop)      count_nxt = count + 1'b1;
    else if (pop && !wr) count_nxt = count - 1'b1;
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= {ext_flag, brk_flag, byte_data};
  end

  // FIFO pointers, occupancy, full flag and overflow strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      fifo_full <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count     <= count_nxt;
      fifo_full <= (count_nxt == CW'(FIFO_DEPTH));
      overflow  <= push && is_full && !pop;
    end
  end

  // First-word-fall-through head, zeroed while empty
  always_comb begin
    head      = mem[rd_ptr];
    key_valid = !is_empty;
    key_code  = is_empty ? 8'h00 : head[7:0];
    key_break = is_empty ? 1'b0  : head[8];
    key_ext   = is_empty ? 1'b0  : head[9];
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - directed table-driven bench for ps2_key_decoder
`timescale 1ns/1ps
module tb_ps2_key_decoder;

  localparam int FL    = 4;
  localparam int TO    = 200;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n, kclk, kdata, rd_en;
  logic       key_valid, key_ext, key_break, fifo_full, frame_err, overflow;
  logic [7:0] key_code;

  int n_vec  = 0;
  int n_miss = 0;
  int err_cnt = 0;
  int ovf_cnt = 0;

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .kclk(kclk), .kdata(kdata), .rd_en(rd_en),
    .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext), .key_break(key_break),
    .fifo_full(fifo_full), .frame_err(frame_err), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) err_cnt++;
    if (overflow)  ovf_cnt++;
  end

  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    bit         bad_stop;
    bit         exp_valid;
    logic [7:0] exp_code;
    bit         exp_ext;
    bit         exp_brk;
    int         exp_err;
    bit         chk_lat;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_bit(input logic b);
    kdata = b;
    wait_ticks(10);
    kclk = 1'b0;
    wait_ticks(20);
    kclk = 1'b1;
    wait_ticks(10);
  endtask

  // Full frame; lat = ticks from the stop-bit clock fall until key_valid rises (0 if it never did)
  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop, output int lat);
    logic was;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(code[i]);
    send_bit((~^code) ^ bad_par);
    kdata = !bad_stop;
    wait_ticks(10);
    kclk = 1'b0;
    lat = 0;
    was = key_valid;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (!was && key_valid && lat == 0) lat = i;
    end
    kclk = 1'b1;
    wait_ticks(10);
    kdata = 1'b1;
    wait_ticks(10);
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " key_valid"}, key_valid, 0);
    check({tag, " key_code"},  key_code,  0);
    check({tag, " key_ext"},   key_ext,   0);
    check({tag, " key_break"}, key_break, 0);
    check({tag, " fifo_full"}, fifo_full, 0);
    check({tag, " frame_err"}, frame_err, 0);
    check({tag, " overflow"},  overflow,  0);
  endtask

  initial begin
    int lat, e0, o0;

    //               code   bpar bstop valid ecode  ext brk err lat
    tbl[0]  = '{8'h1C, 0, 0, 1, 8'h1C, 0, 0, 0, 1};
    tbl[1]  = '{8'hF0, 0, 0, 0, 8'h00, 0, 0, 0, 0};
    tbl[2]  = '{8'h1C, 0, 0, 1, 8'h1C, 0, 1, 0, 0};
    tbl[3]  = '{8'hE0, 0, 0, 0, 8'h00, 0, 0, 0, 0};
    tbl[4]  = '{8'hF0, 0, 0, 0, 8'h00, 0, 0, 0, 0};
    tbl[5]  = '{8'h75, 0, 0, 1, 8'h75, 1, 1, 0, 1};
`ifdef PS2_PARITY_CHECK_EN
    tbl[6]  = '{8'h1C, 1, 0, 0, 8'h00, 0, 0, 1, 0};
`else
    tbl[6]  = '{8'h1C, 1, 0, 1, 8'h1C, 0, 0, 0, 0};
`endif
    tbl[7]  = '{8'h1C, 0, 1, 0, 8'h00, 0, 0, 1, 0};
    tbl[8]  = '{8'h29, 0, 0, 1, 8'h29, 0, 0, 0, 0};
    tbl[9]  = '{8'hE0, 0, 0, 0, 8'h00, 0, 0, 0, 0};
    tbl[10] = '{8'h1C, 0, 1, 0, 8'h00, 0, 0, 1, 0};
    tbl[11] = '{8'h1C, 0, 0, 1, 8'h1C, 0, 0, 0, 0};

    rst_n = 1'b0; kclk = 1'b1; kdata = 1'b1; rd_en = 1'b0;
    wait_ticks(5);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    wait_ticks(10);

    for (int i = 0; i < 12; i++) begin
      e0 = err_cnt;
      send_frame(tbl[i].code, tbl[i].bad_par, tbl[i].bad_stop, lat);
      wait_ticks(5);
      check($sformatf("v%0d key_valid", i), key_valid, tbl[i].exp_valid);
      check($sformatf("v%0d frame_err count", i), err_cnt - e0, tbl[i].exp_err);
      if (tbl[i].exp_valid) begin
        check($sformatf("v%0d key_code", i), key_code, tbl[i].exp_code);
        check($sformatf("v%0d key_ext", i), key_ext, tbl[i].exp_ext);
        check($sformatf("v%0d key_break", i), key_break, tbl[i].exp_brk);
        if (tbl[i].chk_lat) check($sformatf("v%0d latency", i), lat, FL + 5);
        pop();
        check($sformatf("v%0d key_valid after pop", i), key_valid, 0);
      end
    end

    // Watchdog: clock stalls after four data bits
    e0 = err_cnt;
    send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    wait_ticks(TO + 50);
    check("timeout frame_err count", err_cnt - e0, 1);
    check("timeout key_valid", key_valid, 0);
    send_frame(8'h29, 0, 0, lat);
    wait_ticks(5);
    check("post-timeout key_valid", key_valid, 1);
    check("post-timeout key_code", key_code, 8'h29);
    pop();

    // Fill past capacity without reading
    o0 = ovf_cnt;
    for (int i = 0; i < DEPTH + 1; i++) begin
      send_frame(8'h40 + 8'(i), 0, 0, lat);
      wait_ticks(5);
      if (i == DEPTH - 2) check("fifo_full at 7", fifo_full, 0);
      if (i == DEPTH - 1) begin
        check("fifo_full at 8", fifo_full, 1);
        check("no overflow at 8", ovf_cnt - o0, 0);
      end
    end
    check("overflow on 9th", ovf_cnt - o0, 1);
    check("fifo_full after 9th", fifo_full, 1);
    for (int i = 0; i < DEPTH; i++) begin
      check($sformatf("drain %0d key_valid", i), key_valid, 1);
      check($sformatf("drain %0d key_code", i), key_code, 8'h40 + 8'(i));
      pop();
      if (i == 0) check("fifo_full after pop", fifo_full, 0);
    end
    check("drained key_valid", key_valid, 0);

    // Reset in the middle of a frame with an event queued
    send_frame(8'h1C, 0, 0, lat);
    wait_ticks(5);
    check("pre-reset key_valid", key_valid, 1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle_outputs("midreset");
    kdata = 1'b1;
    wait_ticks(20);
    e0 = err_cnt;
    send_frame(8'h16, 0, 0, lat);
    wait_ticks(5);
    check("post-reset key_valid", key_valid, 1);
    check("post-reset key_code", key_code, 8'h16);
    check("post-reset key_ext", key_ext, 0);
    check("post-reset key_break", key_break, 0);
    check("post-reset frame_err count", err_cnt - e0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
